// File: rtl/pulse_cdc_sync_mc.sv
// Multi-channel pulse/event synchroniser into the clk domain with sticky pending/overrun flags.
// Optional per-channel saturating miss counters: define PULSE_CDC_SYNC_MC_MISS_CNT_EN.
module pulse_cdc_sync_mc #(
    parameter int NUM_CH     = 4,
    parameter int NUM_STAGES = 2,
    parameter int MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     data_in,
    input  logic [NUM_CH-1:0]     ack,
    input  logic                  overrun_clr,
    output logic [NUM_CH-1:0]     sync_pulse,
    output logic [NUM_CH-1:0]     pending,
    output logic [NUM_CH-1:0]     overrun,
    output logic [8*NUM_CH-1:0]   miss_cnt
);

    localparam int              WU_MAX  = NUM_STAGES + 1;
    localparam int              WU_W    = $clog2(WU_MAX + 1);
    localparam logic [WU_W-1:0] WU_DONE = WU_W'(WU_MAX);

    logic [NUM_CH-1:0] sync_p0 [NUM_STAGES];
    logic [NUM_CH-1:0] sync_last;
    logic [NUM_CH-1:0] hist_p1;
    logic [WU_W-1:0]   wu_cnt;
    logic [NUM_CH-1:0] raw_evt;
    logic [NUM_CH-1:0] evt;
    logic [NUM_CH-1:0] miss_evt;

    // Stage p0: metastability chain, one vector of flops per stage across all channels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_STAGES; k++) sync_p0[k] <= '0;
            hist_p1 <= '0;
        end else begin
            sync_p0[0] <= data_in;
            for (int k = 1; k < NUM_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
            hist_p1 <= sync_last;
        end
    end

    assign sync_last = sync_p0[NUM_STAGES-1];

    // Events are ignored until the chain and history have been refilled after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wu_cnt <= '0;
        end else if (wu_cnt != WU_DONE) begin
            wu_cnt <= wu_cnt + WU_W'(1);
        end
    end

    generate
        if (MODE == 1) begin : g_rise
            assign raw_evt = sync_last & ~hist_p1;
        end else begin : g_toggle
            assign raw_evt = sync_last ^ hist_p1;
        end
    endgenerate

    assign evt      = (wu_cnt == WU_DONE) ? raw_evt : '0;
    assign miss_evt = evt & pending & ~ack;

    // Stage p1: registered strobe and sticky flags; a new set beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_pulse <= '0;
            pending    <= '0;
            overrun    <= '0;
        end else begin
            sync_pulse <= evt;
            pending    <= evt | (pending & ~ack);
            overrun    <= miss_evt | (overrun & ~{NUM_CH{overrun_clr}});
        end
    end

`ifdef PULSE_CDC_SYNC_MC_MISS_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] cnt_q [NUM_CH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (overrun_clr) begin
                    cnt_q[i] <= miss_evt[i] ? 8'd1 : 8'd0;
                end else if (miss_evt[i]) begin
                    cnt_q[i] <= sat_inc8(cnt_q[i]);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
        assign miss_cnt[8*gi +: 8] = cnt_q[gi];
    end
`else
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_cdc_sync_mc.sv
// Directed bench for pulse_cdc_sync_mc: MODE 0 and MODE 1 instances on a shared clock and reset.
module tb_pulse_cdc_sync_mc;

`ifdef PULSE_CDC_SYNC_MC_MISS_CNT_EN
    localparam bit MISS_EN   = 1'b1;
    localparam int N_OVERRUN = 300;
`else
    localparam bit MISS_EN   = 1'b0;
    localparam int N_OVERRUN = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d0, ack0, d1, ack1;
    logic        clr0, clr1;
    logic [3:0]  pulse0, pend0, ovr0, pulse1, pend1, ovr1;
    logic [31:0] miss0, miss1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_cdc_sync_mc #(.NUM_CH(4), .NUM_STAGES(2), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .data_in(d0), .ack(ack0), .overrun_clr(clr0),
        .sync_pulse(pulse0), .pending(pend0), .overrun(ovr0), .miss_cnt(miss0)
    );

    pulse_cdc_sync_mc #(.NUM_CH(4), .NUM_STAGES(2), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .data_in(d1), .ack(ack1), .overrun_clr(clr1),
        .sync_pulse(pulse1), .pending(pend1), .overrun(ovr1), .miss_cnt(miss1)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        logic [31:0] exp_miss;

        reset = 1'b0;
        d0 = 4'b0101; ack0 = '0; clr0 = 1'b0;
        d1 = 4'b0000; ack1 = '0; clr1 = 1'b0;
        step(3);
        chk("reset_pulse",   {28'd0, pulse0}, 32'd0);
        chk("reset_pending", {28'd0, pend0},  32'd0);
        chk("reset_overrun", {28'd0, ovr0},   32'd0);
        chk("reset_miss",    miss0,           32'd0);

        // static 0101 across release must not produce events
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("warmup_static_pulse", {28'd0, pulse0}, 32'd0);
        end
        chk("warmup_static_pending", {28'd0, pend0}, 32'd0);

        // single toggle on channel 2: latency and ack
        d0 = d0 ^ 4'b0100;
        step(2);
        chk("lat_early", {28'd0, pulse0}, 32'd0);
        step(1);
        chk("lat_pulse",   {28'd0, pulse0}, 32'h4);
        chk("lat_pending", {28'd0, pend0},  32'h4);
        step(1);
        chk("lat_one_cycle",    {28'd0, pulse0}, 32'd0);
        chk("pending_sticky",   {28'd0, pend0},  32'h4);
        ack0 = 4'b0100;
        step(1);
        ack0 = '0;
        chk("ack_clears", {28'd0, pend0}, 32'd0);
        ack0 = 4'b0100;
        step(1);
        ack0 = '0;
        chk("ack_idle_ignored", {28'd0, pend0}, 32'd0);

        // MODE 1: rise gives one pulse, fall gives none
        cnt_a = 0;
        d1[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (pulse1[0]) cnt_a++;
            if (i == 2) chk("m1_pending", {28'd0, pend1}, 32'h1);
        end
        cnt_b = 0;
        d1[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (pulse1[0]) cnt_b++;
        end
        chk("m1_rise_count", cnt_a, 32'd1);
        chk("m1_fall_count", cnt_b, 32'd0);

        // channel 1: two events 8 cycles apart without ack
        d0 = d0 ^ 4'b0010;
        step(3);
        chk("ch1_first_pulse", {28'd0, pulse0}, 32'h2);
        step(5);
        d0 = d0 ^ 4'b0010;
        step(3);
        chk("ch1_second_pulse", {28'd0, pulse0}, 32'h2);
        chk("ch1_overrun",      {28'd0, ovr0},   32'h2);
        chk("ch1_pending",      {28'd0, pend0},  32'h2);
        exp_miss = MISS_EN ? 32'h0000_0100 : 32'd0;
        chk("ch1_miss", miss0, exp_miss);
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        chk("ch1_clr_overrun", {28'd0, ovr0}, 32'd0);
        chk("ch1_clr_miss",    miss0,         32'd0);
        ack0 = 4'b0010;
        step(1);
        ack0 = '0;
        chk("ch1_ack", {28'd0, pend0}, 32'd0);

        // channel 1: second event coincides with ack
        d0 = d0 ^ 4'b0010;
        step(3);
        chk("ch1b_pending", {28'd0, pend0}, 32'h2);
        d0 = d0 ^ 4'b0010;
        step(2);
        ack0 = 4'b0010;
        step(1);
        ack0 = '0;
        chk("ack_evt_pulse",   {28'd0, pulse0}, 32'h2);
        chk("ack_evt_pending", {28'd0, pend0},  32'h2);
        chk("ack_evt_overrun", {28'd0, ovr0},   32'd0);
        chk("ack_evt_miss",    miss0,           32'd0);
        ack0 = 4'b0010;
        step(1);
        ack0 = '0;

        // channel 3: repeated overruns, then clear coinciding with a new one
        d0 = d0 ^ 4'b1000;
        step(3);
        chk("ch3_first_pending", {28'd0, pend0}, 32'h8);
        for (int i = 0; i < N_OVERRUN; i++) begin
            d0 = d0 ^ 4'b1000;
            step(3);
        end
        chk("ch3_overrun", {28'd0, ovr0}, 32'h8);
        exp_miss = MISS_EN ? 32'hFF00_0000 : 32'd0;
        chk("ch3_miss_sat", miss0, exp_miss);
        d0 = d0 ^ 4'b1000;
        step(2);
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        chk("clr_vs_set_overrun", {28'd0, ovr0}, 32'h8);
        exp_miss = MISS_EN ? 32'h0100_0000 : 32'd0;
        chk("clr_vs_set_miss", miss0, exp_miss);
        clr0 = 1'b1;
        step(1);
        clr0 = 1'b0;
        chk("ch3_clr_overrun", {28'd0, ovr0}, 32'd0);
        chk("ch3_clr_miss",    miss0,         32'd0);
        ack0 = 4'b1000;
        step(1);
        ack0 = '0;
        chk("ch3_ack", {28'd0, pend0}, 32'd0);

        // reset mid-operation
        d0 = d0 ^ 4'b1111;
        step(3);
        chk("all_pulse",   {28'd0, pulse0}, 32'hF);
        chk("all_pending", {28'd0, pend0},  32'hF);
        d0 = d0 ^ 4'b0100;
        step(3);
        chk("pre_reset_overrun", {28'd0, ovr0}, 32'h4);
        d0 = d0 ^ 4'b0001;
        step(1);
        reset = 1'b0;
        #1;
        chk("async_rst_pulse",   {28'd0, pulse0}, 32'd0);
        chk("async_rst_pending", {28'd0, pend0},  32'd0);
        chk("async_rst_overrun", {28'd0, ovr0},   32'd0);
        chk("async_rst_miss",    miss0,           32'd0);
        step(2);
        reset = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (pulse0 != 4'b0000) cnt_a++;
        end
        chk("rerelease_no_pulse",   cnt_a,           32'd0);
        chk("rerelease_no_pending", {28'd0, pend0},  32'd0);
        d0 = d0 ^ 4'b0010;
        step(2);
        chk("resume_early", {28'd0, pulse0}, 32'd0);
        step(1);
        chk("resume_pulse",   {28'd0, pulse0}, 32'h2);
        chk("resume_pending", {28'd0, pend0},  32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_cdc_sync_mc.md
# pulse_cdc_sync_mc

Multi-channel pulse/event synchroniser: brings NUM_CH asynchronous event signals from foreign clock domains into the `clk` domain. Each channel emits a one-cycle `sync_pulse` per detected event and holds a sticky `pending` flag until the consumer acknowledges it. Missed events, where a new event arrives while the previous one is still pending, are flagged per channel. Sits at the CDC boundary between the controller core and the AHB/register side, replacing per-signal single-bit synchronisers.

## Interface
- NUM_CH, 4, number of independent channels (1..32)
- NUM_STAGES, 2, metastability flops per channel (minimum 2)
- MODE, 0, event definition: 0 = any transition of `data_in` (toggle protocol), 1 = rising edge only

- clk  in  1  destination clock
- reset  in  1  asynchronous, active-low reset (asserts immediately, deassertion sampled by `clk`)
- data_in  in  NUM_CH  asynchronous event inputs, one per channel
- ack  in  NUM_CH  per-channel acknowledge; clears `pending`
- overrun_clr  in  1  clears all `overrun` bits (and `miss_cnt` when compiled in)
- sync_pulse  out  NUM_CH  one-cycle event strobe per channel
- pending  out  NUM_CH  sticky event-waiting flag per channel
- overrun  out  NUM_CH  sticky lost-event flag per channel
- miss_cnt  out  8*NUM_CH  per-channel missed-event counters; channel i at [8i+7:8i]

## Operation
- Per channel: chain `s[0..NUM_STAGES-1]` clocked by `clk`, plus history flop `h <= s[NUM_STAGES-1]`.
- Raw event: MODE 0 `s[last] ^ h`; MODE 1 `s[last] & ~h`.
- Warm-up: a shared counter runs from reset deassertion and saturates at NUM_STAGES+1. Raw events are masked while count < NUM_STAGES+1. Chain and history flops run normally during warm-up, so a `data_in` held static high across reset produces no event.
- `sync_pulse[i]` is registered: high for exactly one cycle per qualified event.
- `pending[i]` updates on the same edge as `sync_pulse[i]`:
  - event and no ack: set
  - ack and no event: clear
  - event and ack together: stays 1 (the ack consumes the old event, the new one stays pending); no overrun
  - ack while `pending` = 0: ignored
- `overrun[i]` sets when an event occurs while `pending[i]` = 1 and `ack[i]` = 0. It is sticky. `overrun_clr` clears it; a set in the same cycle as the clear wins.
- Channels are fully independent; no ordering between channels is guaranteed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: all chain, history, warm-up, `sync_pulse`, `pending`, `overrun`, `miss_cnt` = 0.
- Latency: for a `data_in` change meeting setup before rising edge E0, `sync_pulse` is high in the cycle following edge E(NUM_STAGES). That is NUM_STAGES+1 edges, with ±1 cycle uncertainty for a truly asynchronous source.
- Minimum event spacing at the source: NUM_STAGES+1 destination cycles. Closer events in MODE 0 may cancel; this is the source's responsibility and is not detected.
- Reset asserted mid-operation: all state clears asynchronously, events in flight are discarded, and warm-up restarts on release.
- `ack` and `overrun_clr` are sampled synchronously and take effect on the next edge.

## Configuration
- `PULSE_CDC_SYNC_MC_MISS_CNT_EN`:
  - Defined: each channel has an 8-bit counter that increments on every overrun-condition event and saturates at 255. `overrun_clr` zeroes it; an increment in the same cycle as the clear leaves the counter at 1.
  - Undefined: no counter logic is built and `miss_cnt` is tied to 0. The port list is unchanged.

## Test plan
- Reset release with `data_in` = 4'b0101 held static (MODE 0, NUM_STAGES 2) -> no `sync_pulse` and `pending` = 0 for 20 cycles.
- Toggle `data_in[2]` one cycle before edge E0 -> `sync_pulse` = 4'b0100 for one cycle after E2, `pending[2]` = 1; `ack[2]` pulse -> `pending[2]` = 0 on next edge.
- MODE 1: `data_in[0]` rises, then falls 10 cycles later -> exactly one `sync_pulse[0]`; the fall produces none.
- Two events on channel 1 spaced 8 cycles apart with no ack -> `overrun[1]` = 1 and `miss_cnt[15:8]` = 1 (macro on) or 0 (macro off). Second event coinciding with `ack[1]` -> `overrun[1]` stays 0, `pending[1]` stays 1.
- With the macro defined, 300 overrun events on channel 3 -> `miss_cnt[31:24]` saturates at 255. Then `overrun_clr` asserted in the same cycle as a new overrun event -> `overrun[3]` = 1, counter = 1.
- Assert `reset` while `pending` = 4'b1111 and an event is mid-chain -> all outputs 0 immediately. After release: no pulse during warm-up, and normal operation resumes for subsequent toggles.
